// File: rtl/multi_entry_display_pkg.sv
// Shared types and 7-segment helpers for the multi-entry display block.
// Segment vectors are active-low, bit order gfedcba.
package multi_entry_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      4'hF:    return 7'b0001110;
      default: return BLANK;
    endcase
  endfunction

endpackage

// File: rtl/multi_entry_display_seg7_decode.sv
// One digit of the display: 4-bit nibble to active-low gfedcba segments.
module seg7_decode
  import multi_entry_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex2seg(nibble);
endmodule

// File: rtl/multi_entry_display.sv
// Button-driven entry stack whose top entry is shown on NUM_DIGITS 7-segment
// digits, either as hex or as decimal via a serial double-dabble converter.
module multi_entry_display
  import multi_entry_display_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       nenter,
  input  logic                       nback,
  input  logic                       mode,
  input  logic [DATA_W-1:0]          inputdata,
  output logic [NUM_DIGITS*7-1:0]    disp,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       busy,
  output logic                       err
);
  localparam int CW         = $clog2(DEPTH+1);
  localparam int DW         = NUM_DIGITS*4;
  // BCD register holds every decimal digit DATA_W can produce, so overflow
  // past NUM_DIGITS is visible as nonzero upper digits.
  localparam int DEC_DIGITS = (DATA_W*301)/1000 + 1;
  localparam int BCD_DIGITS = (DEC_DIGITS > NUM_DIGITS) ? DEC_DIGITS : NUM_DIGITS;
  localparam int BCD_W      = BCD_DIGITS*4;
  localparam int BW         = $clog2(DATA_W+1);

  if (NUM_DIGITS*4 < DATA_W || DEPTH < 1) begin : g_bad_cfg
    $error("multi_entry_display: NUM_DIGITS*4 must cover DATA_W and DEPTH must be >= 1");
  end

  // Button synchronizers: [0],[1] are the sync flops, [2] is the previous value.
  logic [2:0] ent_q, ent_d, bck_q, bck_d;
  logic       push_p, pop_p;

  always_comb begin
    ent_d = {ent_q[1:0], nenter};
    bck_d = {bck_q[1:0], nback};
  end

  assign push_p = ent_q[2] & ~ent_q[1];
  assign pop_p  = bck_q[2] & ~bck_q[1];

  // Entry stack
  logic [DATA_W-1:0] stack_q [DEPTH];
  logic [DATA_W-1:0] stack_d [DEPTH];
  logic [CW-1:0]     count_q, count_d, wr_idx;
  logic              err_q, err_d, wr_en, full_w;

  assign full_w = (count_q == CW'(DEPTH));

  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    if (push_p && pop_p && count_q != '0) begin
      wr_en  = 1'b1;
      wr_idx = count_q - CW'(1);
    end else if (push_p) begin
      if (full_w) begin
        err_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = count_q;
        count_d = count_q + CW'(1);
      end
    end else if (pop_p) begin
      if (count_q == '0) err_d = 1'b1;
      else               count_d = count_q - CW'(1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (wr_en && wr_idx == CW'(i)) stack_d[i] = inputdata;
    end
  end

  // Current top entry and display-event detection against last cycle's view
  logic [DATA_W-1:0] cur_val, snap_val_q, snap_val_d;
  logic              cur_empty, snap_empty_q, snap_empty_d, snap_mode_q, snap_mode_d;
  logic              evt;

  always_comb begin
    cur_val = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) == count_q - CW'(1)) cur_val = stack_q[i];
  end

  assign cur_empty = (count_q == '0);
  assign evt = (cur_empty != snap_empty_q) || (mode != snap_mode_q) ||
               (!cur_empty && cur_val != snap_val_q);

  // Double-dabble datapath: add-3 correction then shift in the next binary bit
  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj, bcd_nxt;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic              dash_q, dash_d;
  logic              last, ovf, reeval;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (bcd_q[i*4 +: 4] > 4'd4) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    bcd_nxt = BCD_W'({bcd_adj, sh_q[DATA_W-1]});
    ovf     = (bcd_nxt >> DW) != '0;
    last    = (cnt_q == BW'(DATA_W-1));
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    sh_d         = sh_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    digits_d     = digits_q;
    dash_d       = dash_q;
    snap_val_d   = cur_val;
    snap_empty_d = cur_empty;
    snap_mode_d  = mode;
    reeval       = 1'b0;
    if (state_q == IDLE) begin
      reeval = evt;
    end else begin
      sh_d  = sh_q << 1;
      bcd_d = bcd_nxt;
      cnt_d = cnt_q + BW'(1);
      if (evt) pend_d = 1'b1;
      if (last) begin
        // A result whose source changed mid-flight is dropped, never shown.
        if (pend_q || evt) begin
          reeval = 1'b1;
        end else begin
          state_d  = IDLE;
          digits_d = bcd_nxt[DW-1:0];
          dash_d   = ovf;
        end
      end
    end
    if (reeval) begin
      pend_d  = 1'b0;
      state_d = IDLE;
      if (cur_empty) begin
        dash_d = 1'b1;
      end else if (!mode) begin
        digits_d = DW'(cur_val);
        dash_d   = 1'b0;
      end else begin
        state_d = CONV;
        sh_d    = cur_val;
        bcd_d   = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ent_q        <= 3'b111;
      bck_q        <= 3'b111;
      count_q      <= '0;
      err_q        <= 1'b0;
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      sh_q         <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      digits_q     <= '0;
      dash_q       <= 1'b1;
      snap_val_q   <= '0;
      snap_empty_q <= 1'b1;
      snap_mode_q  <= 1'b0;
    end else begin
      ent_q        <= ent_d;
      bck_q        <= bck_d;
      count_q      <= count_d;
      err_q        <= err_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
      sh_q         <= sh_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      dash_q       <= dash_d;
      snap_val_q   <= snap_val_d;
      snap_empty_q <= snap_empty_d;
      snap_mode_q  <= snap_mode_d;
    end
  end

  // Stack contents survive reset; only count marks them valid.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [6:0] seg;
    seg7_decode u_dec (
      .nibble (digits_q[g*4 +: 4]),
      .seg    (seg)
    );
    assign disp[g*7 +: 7] = (dash_q || cur_empty) ? DASH : seg;
  end

  assign count = count_q;
  assign full  = full_w;
  assign busy  = (state_q == CONV);
  assign err   = err_q;

endmodule

// File: tb/tb_multi_entry_display.sv
// Scoreboard bench: stimulus pushes timed expectations from a queue-based
// stack model; a negedge monitor pops and compares them against the DUT.
module tb_multi_entry_display;
  localparam int DATA_W     = 8;
  localparam int NUM_DIGITS = 4;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH+1);
  localparam int DISP_W     = NUM_DIGITS*7;

  // Active-high gfedcba patterns for 0..F; the display wants them inverted.
  localparam logic [6:0] SEG_HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [6:0] DASH_L = 7'h3F;

  logic              clk = 1'b0;
  logic              nreset = 1'b1;
  logic              nenter = 1'b1;
  logic              nback = 1'b1;
  logic              mode = 1'b0;
  logic [DATA_W-1:0] inputdata = '0;
  logic [DISP_W-1:0] disp;
  logic [CW-1:0]     count;
  logic              full, busy, err;

  multi_entry_display #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .nenter    (nenter),
    .nback     (nback),
    .mode      (mode),
    .inputdata (inputdata),
    .disp      (disp),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: err/count/full at exact cycle; 1: display once settled; 2: reset state
  typedef struct {
    int                kind;
    int                due;
    logic [DISP_W-1:0] dsp;
    int                cnt;
    bit                fl;
    bit                er;
    int                id;
  } exp_t;

  exp_t        sbq[$];
  int          exp_busy_q[$];
  int unsigned mstack[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          tag = 0;
  int          brun = 0;

  function automatic exp_t mk(input int kind, input int due, input logic [DISP_W-1:0] dsp,
                              input int cnt, input bit fl, input bit er, input int id);
    exp_t e;
    e.kind = kind; e.due = due; e.dsp = dsp; e.cnt = cnt; e.fl = fl; e.er = er; e.id = id;
    return e;
  endfunction

  function automatic logic [DISP_W-1:0] exp_disp(input int unsigned v, input bit empty, input bit dec);
    logic [DISP_W-1:0] r;
    int unsigned lim, pw;
    lim = 1;
    for (int i = 0; i < NUM_DIGITS; i++) lim = lim * 10;
    if (empty || (dec && v >= lim)) return {NUM_DIGITS{DASH_L}};
    r  = '0;
    pw = 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      int unsigned d;
      d = dec ? (v / pw) % 10 : (v >> (4*i)) & 15;
      r[i*7 +: 7] = ~SEG_HI[d];
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic logic [DISP_W-1:0] cur_exp();
    if (mstack.size() == 0) return exp_disp(0, 1'b1, mode);
    return exp_disp(mstack[mstack.size()-1], 1'b0, mode);
  endfunction

  task automatic chk(input string nm, input int id, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s [tag %0d] at cycle %0d: got %0h, expected %0h", nm, id, cyc, got, want);
    end
  endtask

  // Monitor: busy-run length plus the timed scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   eb;
    if (!nreset) begin
      brun = 0;
    end else if (busy) begin
      brun++;
    end else begin
      if (brun > 0 && exp_busy_q.size() > 0) begin
        eb = exp_busy_q.pop_front();
        chk("busy_len", 0, brun, eb);
      end
      brun = 0;
    end
    if (sbq.size() > 0) begin
      e = sbq[0];
      if (e.kind == 1) begin
        if (cyc >= e.due && !busy) begin
          e = sbq.pop_front();
          chk("disp", e.id, disp, e.dsp);
          chk("disp_count", e.id, count, e.cnt);
        end else if (cyc > e.due + 60) begin
          e = sbq.pop_front();
          chk("disp_settle_timeout", e.id, busy, 0);
        end
      end else if (cyc >= e.due) begin
        e = sbq.pop_front();
        if (cyc != e.due) begin
          chk("missed_sample", e.id, cyc, e.due);
        end else if (e.kind == 0) begin
          chk("err", e.id, err, e.er);
          chk("count", e.id, count, e.cnt);
          chk("full", e.id, full, e.fl);
        end else begin
          chk("rst_disp", e.id, disp, e.dsp);
          chk("rst_count", e.id, count, 0);
          chk("rst_busy", e.id, busy, 0);
          chk("rst_full", e.id, full, 0);
          chk("rst_err", e.id, err, 0);
        end
      end
    end
  end

  task automatic drain();
    int g = 0;
    while (sbq.size() > 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
  endtask

  // One button press: model updated, expectations queued, buttons held 4 cycles.
  task automatic press(input bit e, input bit b, input logic [DATA_W-1:0] d, input bit chk_disp);
    bit exp_err;
    @(negedge clk);
    inputdata = d;
    exp_err = 1'b0;
    if (e && b && mstack.size() > 0) mstack[mstack.size()-1] = d;
    else if (e) begin
      if (mstack.size() == DEPTH) exp_err = 1'b1;
      else mstack.push_back(d);
    end else if (b) begin
      if (mstack.size() == 0) exp_err = 1'b1;
      else void'(mstack.pop_back());
    end
    nenter = !e;
    nback  = !b;
    tag++;
    sbq.push_back(mk(0, cyc + 3, '0, mstack.size(), mstack.size() == DEPTH, exp_err, tag));
    if (chk_disp) sbq.push_back(mk(1, cyc + 4, cur_exp(), mstack.size(), 1'b0, 1'b0, tag));
    repeat (4) @(negedge clk);
    nenter = 1'b1;
    nback  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mode(input bit m, input bit chk_disp);
    @(negedge clk);
    mode = m;
    tag++;
    if (chk_disp) sbq.push_back(mk(1, cyc + 1, cur_exp(), mstack.size(), 1'b0, 1'b0, tag));
    drain();
  endtask

  task automatic reset_check();
    @(posedge clk);
    #2 nreset = 1'b0;
    mstack.delete();
    tag++;
    sbq.push_back(mk(2, cyc, {NUM_DIGITS{DASH_L}}, 0, 1'b0, 1'b0, tag));
    drain();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    int op;
    #1 nreset = 1'b0;
    @(posedge clk);
    #2;
    tag++;
    sbq.push_back(mk(2, cyc, {NUM_DIGITS{DASH_L}}, 0, 1'b0, 1'b0, tag));
    drain();
    @(negedge clk);
    nreset = 1'b1;

    // hex push, then decimal view of it, then a decimal push of the maximum value
    press(1'b1, 1'b0, 8'hA5, 1'b1); drain();
    set_mode(1'b1, 1'b1);
    exp_busy_q.push_back(DATA_W);
    press(1'b1, 1'b0, 8'hFF, 1'b1); drain();

    // fill, overfill, empty, over-pop
    press(1'b1, 1'b0, 8'd17, 1'b1); drain();
    press(1'b1, 1'b0, 8'd90, 1'b1); drain();
    press(1'b1, 1'b0, 8'd33, 1'b1); drain();
    repeat (5) begin
      press(1'b0, 1'b1, 8'd0, 1'b1); drain();
    end

    // mode flipped to hex during a conversion
    press(1'b1, 1'b0, 8'd123, 1'b0);
    set_mode(1'b0, 1'b1);
    // mode toggled twice during a conversion: restart, final decimal
    @(negedge clk) mode = 1'b1;
    @(negedge clk);
    @(negedge clk) mode = 1'b0;
    @(negedge clk) mode = 1'b1;
    tag++;
    sbq.push_back(mk(1, cyc + 1, cur_exp(), mstack.size(), 1'b0, 1'b0, tag));
    drain();
    // push accepted while converting; only the newest top is shown
    press(1'b1, 1'b0, 8'd42, 1'b0);
    press(1'b1, 1'b0, 8'd200, 1'b1); drain();

    // simultaneous push+pop: replace top, and on empty behave as push
    press(1'b1, 1'b1, 8'd7, 1'b1); drain();
    repeat (3) begin
      press(1'b0, 1'b1, 8'd0, 1'b1); drain();
    end
    press(1'b1, 1'b1, 8'd99, 1'b1); drain();

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) set_mode(1'($urandom_range(0, 1)), 1'b1);
      op = $urandom_range(0, 3);
      press(op <= 1 || op == 3, op >= 2, 8'($urandom_range(0, 255)), 1'b1);
      drain();
    end

    // reset asserted mid-conversion, then a normal first press
    set_mode(1'b0, 1'b1);
    if (mstack.size() == 0) begin
      press(1'b1, 1'b0, 8'h5A, 1'b1); drain();
    end
    @(negedge clk) mode = 1'b1;
    reset_check();
    press(1'b1, 1'b0, 8'h3C, 1'b1); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_entry_display.md
MULTI_ENTRY_DISPLAY -- requirements
Module: multi_entry_display

Interface
REQ-001 Parameter DATA_W, default 8: width of the entered data word.
REQ-002 Parameter NUM_DIGITS, default 4: number of 7-segment digits driven.
REQ-003 Parameter DEPTH, default 4: number of entries held in the entry stack.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port nreset  input  1: reset, asynchronous, active-low.
REQ-006 Port nenter  input  1: push button, active-low, asynchronous to clk.
REQ-007 Port nback  input  1: pop button, active-low, asynchronous to clk.
REQ-008 Port mode  input  1: display format select; 0 = hex, 1 = decimal.
REQ-009 Port inputdata  input  DATA_W: value pushed on enter.
REQ-010 Port disp  output  NUM_DIGITS*7: segments, active-low, bit order gfedcba per digit; digit 0 in bits [6:0] is least significant.
REQ-011 Port count  output  $clog2(DEPTH+1): number of valid entries.
REQ-012 Port full  output  1: high when count == DEPTH.
REQ-013 Port busy  output  1: high while a decimal conversion is in progress.
REQ-014 Port err  output  1: one-cycle pulse on a rejected push or pop.

Function
REQ-015 nenter and nback SHALL each pass through a 2-flop synchronizer followed by falling-edge detection, giving one push or pop pulse per press.
REQ-016 The stack SHALL be updated on the 3rd rising clk edge after a button falls, provided setup time is met.
REQ-017 Push when not full: inputdata is stored at position count, and count increments.
REQ-018 Push when full: the stack is unchanged and err pulses.
REQ-019 Pop when count > 0: count decrements.
REQ-020 Pop when empty: count stays 0 and err pulses.
REQ-021 Simultaneous push and pop pulses with count > 0: the top entry is replaced by inputdata and count is unchanged.
REQ-022 Simultaneous push and pop pulses with count == 0: treated as a push.
REQ-023 The displayed value is always the top entry.
REQ-024 When count == 0, every digit shows a dash (7'b0111111) and no conversion runs.
REQ-025 FSM states are IDLE and CONV.
REQ-026 A change to the top entry or to mode is a display event.
REQ-027 In hex mode, a display event from IDLE updates disp on the next edge, showing zero-padded hex nibbles.
REQ-028 In decimal mode, a display event from IDLE moves the FSM to CONV.
REQ-029 CONV runs a double-dabble conversion: one shift per cycle, DATA_W cycles, busy high throughout.
REQ-030 After CONV, the FSM returns to IDLE and disp loads the zero-padded BCD digits on that same edge.
REQ-031 A display event during CONV sets a pending flag; on completion, the conversion restarts from the current top entry instead of going to IDLE.
REQ-032 Stale conversion results are never shown.
REQ-033 Stack operations during CONV are accepted normally.
REQ-034 Digits above the value's width show 0.
REQ-035 If the decimal result needs more than NUM_DIGITS digits, every digit shows a dash.
REQ-036 Elaboration SHALL fail if NUM_DIGITS*4 < DATA_W or DEPTH < 1.

Reset
REQ-037 When nreset is low: count=0, full=0, busy=0, err=0, FSM=IDLE, pending=0, synchronizers at 1, and disp shows all dashes, applied immediately without waiting for a clock edge.
REQ-038 Stack contents are not reset.
REQ-039 After nreset deasserts, the first button press is detected normally, with no spurious edge.

Structure
REQ-040 Package multi_entry_display_pkg SHALL hold the FSM state enum, the segment constants (DASH, BLANK) and the hex-to-segment lookup function.
REQ-041 One sub-module, seg7_decode (4-bit nibble in, active-low 7-bit segments out), SHALL be instantiated NUM_DIGITS times.

Verification
REQ-042 Reset: assert nreset low mid-run -> disp all 7'b0111111, count=0 and busy=0 with no clock edge needed.
REQ-043 Hex push: mode=0, push 8'hA5 -> count=1 and digits 0,0,A,5 one cycle after the stack update.
REQ-044 Decimal: mode=1, push 8'hFF -> busy high exactly 8 cycles, then digits 0,2,5,5.
REQ-045 Full: push 5 values with DEPTH=4 -> full=1 after the 4th, one err pulse on the 5th, and the top still shows the 4th value.
REQ-046 Empty: pop all 4 then pop once more -> err pulses, count=0, all dashes.
REQ-047 Overlap: toggle mode during CONV -> pending honoured, final disp matches the current mode and the top entry.
